// File: rtl/scene_int_ctl_pkg.sv
// rtl/scene_int_ctl_pkg.sv - shared raytracer types and defaults for the scene intersection controller
package scene_int_ctl_pkg;

    typedef logic [31:0] float_t;
    typedef logic [7:0]  rayID_t;

    typedef struct packed {
        float_t orig_x;
        float_t orig_y;
        float_t orig_z;
        float_t dir_x;
        float_t dir_y;
        float_t dir_z;
    } prg_ray_t;

    localparam int SI_LAT_DEF     = 48;
    localparam int FIFO_DEPTH_DEF = 16;

    // Result entry layout: {rayID, tmin, tmax, miss}
    localparam int RES_W = $bits(rayID_t) + 2 * $bits(float_t) + 1;

endpackage

// File: rtl/scene_int_ctl_fifo.sv
// rtl/scene_int_ctl_fifo.sv - si_res_fifo: circular FIFO with combinational head and counted occupancy
module si_res_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/scene_int_ctl.sv
// rtl/scene_int_ctl.sv - issues rays to scene_int_pl in X/Y/Z phases and collects results under credit flow control
module scene_int_ctl
    import scene_int_ctl_pkg::*;
#(
    parameter int SI_LAT     = SI_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  prg_ray_t ray_in,
    input  rayID_t   rayID_in,
    input  logic     isShadow_in,
    input  logic     ray_in_valid,
    output logic     ray_in_ready,
    output prg_ray_t si_ray,
    output logic     si_v0,
    output logic     si_v1,
    output logic     si_v2,
    output logic     si_isShadow,
    input  float_t   si_tmin,
    input  float_t   si_tmax,
    input  logic     si_miss,
    output logic     out_valid,
    input  logic     out_ready,
    output rayID_t   out_rayID,
    output float_t   out_tmin,
    output float_t   out_tmax,
    output logic     out_miss
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, X, Y, Z, TAIL} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credit_sum;
    logic               credit_ok;
    logic               accept;
    logic               capture;
    logic [SI_LAT-1:0]  tok;
    rayID_t             held_id;
    rayID_t             head_id;
    logic [RES_W-1:0]   res_head;

    // Every ray already issued owns a FIFO slot, so capture never meets a full FIFO.
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);
    assign accept     = ray_in_valid && ray_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ray_in_ready = 1'b0;
        si_v0        = 1'b0;
        si_v1        = 1'b0;
        si_v2        = 1'b0;
        unique case (state)
            IDLE: begin
                ray_in_ready = rst && credit_ok;
                if (ray_in_valid && ray_in_ready) begin
                    state_nxt = X;
                end
            end
            X: begin
                si_v0     = 1'b1;
                state_nxt = Y;
            end
            Y: begin
                si_v1     = 1'b1;
                state_nxt = Z;
            end
            Z: begin
                si_v2     = 1'b1;
                state_nxt = TAIL;
            end
            TAIL: begin
                ray_in_ready = rst && credit_ok;
                state_nxt    = (ray_in_valid && ray_in_ready) ? X : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            si_ray      <= ray_in;
            si_isShadow <= isShadow_in;
            held_id     <= rayID_in;
        end
    end

    // Token marks the cycle scene_int_pl presents the ray issued SI_LAT cycles earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok <= '0;
        end else begin
            tok <= {tok[SI_LAT-2:0], si_v0};
        end
    end

    assign capture = tok[SI_LAT-1];

    si_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rayID_t))
    ) u_id_q (
        .clk       (clk),
        .rst       (rst),
        .push      (si_v0),
        .push_data (held_id),
        .pop       (capture),
        .head_data (head_id),
        .count     (inflight)
    );

    si_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data ({head_id, si_tmin, si_tmax, si_miss}),
        .pop       (out_ready),
        .head_data (res_head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign {out_rayID, out_tmin, out_tmax, out_miss} = res_head;

endmodule

// File: tb/tb_scene_int_ctl.sv
// tb/tb_scene_int_ctl.sv - directed self-checking bench for scene_int_ctl
module tb_scene_int_ctl;
    import scene_int_ctl_pkg::*;

    localparam int LAT   = 48;
    localparam int DEPTH = 16;

    logic     clk = 1'b0;
    logic     rst = 1'b0;
    prg_ray_t ray_in;
    rayID_t   rayID_in;
    logic     isShadow_in;
    logic     ray_in_valid;
    logic     ray_in_ready;
    prg_ray_t si_ray;
    logic     si_v0, si_v1, si_v2, si_isShadow;
    float_t   si_tmin, si_tmax;
    logic     si_miss;
    logic     out_valid, out_ready;
    rayID_t   out_rayID;
    float_t   out_tmin, out_tmax;
    logic     out_miss;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rayID_t           acc_q[$];
    int               acc_cyc[$];
    logic [RES_W-1:0] pop_q[$];

    bit       pipe_v [LAT];
    prg_ray_t pipe_r [LAT];

    always #5 clk = ~clk;

    scene_int_ctl #(.SI_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ray_in       (ray_in),
        .rayID_in     (rayID_in),
        .isShadow_in  (isShadow_in),
        .ray_in_valid (ray_in_valid),
        .ray_in_ready (ray_in_ready),
        .si_ray       (si_ray),
        .si_v0        (si_v0),
        .si_v1        (si_v1),
        .si_v2        (si_v2),
        .si_isShadow  (si_isShadow),
        .si_tmin      (si_tmin),
        .si_tmax      (si_tmax),
        .si_miss      (si_miss),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rayID    (out_rayID),
        .out_tmin     (out_tmin),
        .out_tmax     (out_tmax),
        .out_miss     (out_miss)
    );

    function automatic prg_ray_t mk_ray(input rayID_t id);
        prg_ray_t r;
        r.orig_x = {24'h3F80A5, id};
        r.orig_y = {24'h4000C3, id};
        r.orig_z = {24'h40400F, ~id};
        r.dir_x  = {24'hBF8011, id};
        r.dir_y  = {16'h1234, id, id};
        r.dir_z  = {id, 24'h005A5A};
        return r;
    endfunction

    function automatic float_t f_tmin(input prg_ray_t r);
        return r.orig_x ^ r.dir_y;
    endfunction

    function automatic float_t f_tmax(input prg_ray_t r);
        return r.dir_x + r.orig_z;
    endfunction

    function automatic logic f_miss(input prg_ray_t r);
        return ^r.orig_y;
    endfunction

    function automatic logic [RES_W-1:0] exp_res(input rayID_t id);
        prg_ray_t r;
        r = mk_ray(id);
        return {id, f_tmin(r), f_tmax(r), f_miss(r)};
    endfunction

    // scene_int_pl stand-in: latches the ray seen in its X phase and answers LAT cycles later
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_r[i] <= pipe_r[i-1];
        end
        pipe_v[0] <= si_v0;
        pipe_r[0] <= si_ray;
        cyc <= cyc + 1;
    end

    assign si_tmin = pipe_v[LAT-1] ? f_tmin(pipe_r[LAT-1]) : 32'hDEADBEEF;
    assign si_tmax = pipe_v[LAT-1] ? f_tmax(pipe_r[LAT-1]) : 32'hBADC0FFE;
    assign si_miss = pipe_v[LAT-1] ? f_miss(pipe_r[LAT-1]) : 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            if (ray_in_valid && ray_in_ready) begin
                acc_q.push_back(rayID_in);
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                pop_q.push_back({out_rayID, out_tmin, out_tmax, out_miss});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        acc_cyc.delete();
        pop_q.delete();
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        ray_in_valid = 1'b0;
        ray_in       = mk_ray(8'd0);
        rayID_in     = 8'd0;
        isShadow_in  = 1'b0;
        out_ready    = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (ray_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", ray_in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({si_v0, si_v1, si_v2} !== 3'b000) begin
            errors++; $display("FAIL reset_phase: got %b expected 000", {si_v0, si_v1, si_v2});
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ray_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", ray_in_ready);
        end
        tick();
        clear_q();
    endtask

    task automatic test_single();
        int  n;
        bit  found;
        logic [2:0] exp_v;
        out_ready    = 1'b0;
        ray_in       = mk_ray(8'd5);
        rayID_in     = 8'd5;
        isShadow_in  = 1'b0;
        ray_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ray_in_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b expected 1", ray_in_ready);
        end
        tick();
        ray_in_valid = 1'b0;
        ray_in       = mk_ray(8'hEE);
        rayID_in     = 8'hEE;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_v = (c == 1) ? 3'b100 : (c == 2) ? 3'b010 : (c == 3) ? 3'b001 : 3'b000;
            checks++;
            if ({si_v0, si_v1, si_v2, si_ray} !== {exp_v, mk_ray(8'd5)}) begin
                errors++;
                $display("FAIL single_phase_c%0d: got v=%b ray=%h expected v=%b ray=%h",
                         c, {si_v0, si_v1, si_v2}, si_ray, exp_v, mk_ray(8'd5));
            end
            tick();
        end
        n = 5;
        found = 1'b0;
        while (n <= 60 && !found) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        checks++;
        if (!found || n != LAT + 2) begin
            errors++; $display("FAIL single_latency: got cycle %0d (found=%0b) expected cycle %0d", n, found, LAT + 2);
        end
        checks++;
        if ({out_rayID, out_tmin, out_tmax, out_miss} !== exp_res(8'd5)) begin
            errors++; $display("FAIL single_result: got %h expected %h",
                               {out_rayID, out_tmin, out_tmax, out_miss}, exp_res(8'd5));
        end
        tick();
        @(negedge clk);
        checks++;
        if ({out_valid, out_rayID, out_tmin, out_tmax, out_miss} !== {1'b1, exp_res(8'd5)}) begin
            errors++; $display("FAIL single_hold: got %h expected %h",
                               {out_valid, out_rayID, out_tmin, out_tmax, out_miss}, {1'b1, exp_res(8'd5)});
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop: got out_valid %b expected 0", out_valid);
        end
        tick();
        clear_q();
    endtask

    task automatic test_shadow();
        out_ready    = 1'b1;
        ray_in       = mk_ray(8'd2);
        rayID_in     = 8'd2;
        isShadow_in  = 1'b1;
        ray_in_valid = 1'b1;
        @(negedge clk);
        tick();
        ray_in_valid = 1'b0;
        isShadow_in  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (si_isShadow !== 1'b1) begin
                errors++; $display("FAIL shadow_flag_c%0d: got %b expected 1", c, si_isShadow);
            end
            tick();
        end
        for (int c = 0; c < 80 && pop_q.size() < 1; c++) tick();
        checks++;
        if (pop_q.size() != 1) begin
            errors++; $display("FAIL shadow_count: got %0d results expected 1", pop_q.size());
        end else begin
            checks++;
            if (pop_q[0][32:1] !== f_tmax(mk_ray(8'd2))) begin
                errors++; $display("FAIL shadow_tmax: got %h expected %h", pop_q[0][32:1], f_tmax(mk_ray(8'd2)));
            end
            checks++;
            if (pop_q[0] !== exp_res(8'd2)) begin
                errors++; $display("FAIL shadow_result: got %h expected %h", pop_q[0], exp_res(8'd2));
            end
        end
        clear_q();
    endtask

    task automatic test_stream();
        int k;
        int bad;
        bit acc;
        out_ready    = 1'b1;
        isShadow_in  = 1'b0;
        k            = 0;
        rayID_in     = 8'd100;
        ray_in       = mk_ray(8'd100);
        ray_in_valid = 1'b1;
        for (int c = 0; c < 250 && k < 40; c++) begin
            @(negedge clk);
            acc = ray_in_ready;
            tick();
            if (acc) begin
                k++;
                rayID_in = rayID_t'(100 + k);
                ray_in   = mk_ray(rayID_in);
                if (k == 40) ray_in_valid = 1'b0;
            end
        end
        checks++;
        if (acc_q.size() != 40) begin
            errors++; $display("FAIL stream_accepts: got %0d expected 40", acc_q.size());
        end
        bad = 0;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            if (acc_cyc[i] - acc_cyc[i-1] != 4) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stream_spacing: got %0d gaps not equal to 4 expected 0", bad);
        end
        for (int c = 0; c < 200 && pop_q.size() < 40; c++) tick();
        repeat (8) tick();
        checks++;
        if (pop_q.size() != 40) begin
            errors++; $display("FAIL stream_results: got %0d expected 40", pop_q.size());
        end
        for (int i = 0; i < 40 && i < pop_q.size(); i++) begin
            checks++;
            if (pop_q[i] !== exp_res(rayID_t'(100 + i))) begin
                errors++; $display("FAIL stream_order_%0d: got %h expected %h", i, pop_q[i], exp_res(rayID_t'(100 + i)));
            end
        end
        clear_q();
    endtask

    task automatic test_credit();
        int k;
        bit acc;
        out_ready    = 1'b0;
        k            = 0;
        rayID_in     = 8'd200;
        ray_in       = mk_ray(8'd200);
        ray_in_valid = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            acc = ray_in_ready;
            tick();
            if (acc) begin
                k++;
                rayID_in = rayID_t'(200 + k);
                ray_in   = mk_ray(rayID_in);
            end
        end
        checks++;
        if (acc_q.size() != DEPTH) begin
            errors++; $display("FAIL credit_accepts: got %0d expected %0d", acc_q.size(), DEPTH);
        end
        @(negedge clk);
        checks++;
        if ({ray_in_ready, out_valid} !== 2'b01) begin
            errors++; $display("FAIL credit_stall: got ready=%b valid=%b expected ready=0 valid=1", ray_in_ready, out_valid);
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (pop_q.size() != 1 || pop_q[0] !== exp_res(8'd200)) begin
            errors++; $display("FAIL credit_single_pop: got %0d pops head %h expected 1 pop head %h",
                               pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : '0, exp_res(8'd200));
        end
        acc = 1'b0;
        for (int c = 0; c < 12 && !acc; c++) begin
            @(negedge clk);
            acc = ray_in_ready;
            tick();
        end
        ray_in_valid = 1'b0;
        checks++;
        if (!acc || acc_q.size() != DEPTH + 1 || acc_q[acc_q.size()-1] !== 8'd216) begin
            errors++; $display("FAIL credit_new_accept: got %0d accepts expected %0d with last ID 216", acc_q.size(), DEPTH + 1);
        end
        repeat (LAT) tick();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_rayID} !== {1'b1, 8'd201}) begin
            errors++; $display("FAIL credit_coincide_head: got valid=%b id=%0d expected valid=1 id=201", out_valid, out_rayID);
        end
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (acc_q.size() != DEPTH + 1) begin
            errors++; $display("FAIL credit_no_extra: got %0d accepts expected %0d", acc_q.size(), DEPTH + 1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && pop_q.size() < DEPTH + 1; c++) tick();
        repeat (4) tick();
        out_ready = 1'b0;
        checks++;
        if (pop_q.size() != DEPTH + 1) begin
            errors++; $display("FAIL credit_drain: got %0d pops expected %0d", pop_q.size(), DEPTH + 1);
        end else begin
            for (int i = 1; i <= DEPTH; i++) begin
                checks++;
                if (pop_q[i] !== exp_res(rayID_t'(200 + i))) begin
                    errors++; $display("FAIL credit_order_%0d: got %h expected %h", i, pop_q[i], exp_res(rayID_t'(200 + i)));
                end
            end
        end
        clear_q();
    endtask

    task automatic test_reset_midflight();
        int k;
        bit acc;
        out_ready    = 1'b1;
        k            = 0;
        rayID_in     = 8'd40;
        ray_in       = mk_ray(8'd40);
        ray_in_valid = 1'b1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clk);
            acc = ray_in_ready;
            tick();
            if (acc) begin
                k++;
                rayID_in = rayID_t'(40 + k);
                ray_in   = mk_ray(rayID_in);
                if (k == 6) ray_in_valid = 1'b0;
            end
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_q();
        ray_in       = mk_ray(8'd9);
        rayID_in     = 8'd9;
        ray_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ray_in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready: got %b expected 1", ray_in_ready);
        end
        tick();
        ray_in_valid = 1'b0;
        repeat (120) tick();
        checks++;
        if (pop_q.size() != 1) begin
            errors++; $display("FAIL midreset_count: got %0d results expected 1", pop_q.size());
        end
        checks++;
        if (pop_q.size() < 1 || pop_q[0] !== exp_res(8'd9)) begin
            errors++; $display("FAIL midreset_first: got %h expected %h",
                               (pop_q.size() > 0) ? pop_q[0] : '0, exp_res(8'd9));
        end
        clear_q();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_shadow();
        test_stream();
        test_credit();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
